// File: rtl/snitch_icache_pkg.sv
// Shared definitions for the icache tag path: entry flag layout and tag controller states.
// A tag entry is {valid, error, tag}; the two flag bits sit directly above the tag field.
package snitch_icache_pkg;

    // Bit offsets of the flags relative to the top of the tag field (bit TAG_WIDTH).
    localparam int unsigned TAG_ERROR_BIT = 0;
    localparam int unsigned TAG_VALID_BIT = 1;

    typedef struct packed {
        logic valid;
        logic error;
    } tag_flags_t;

    typedef enum logic [1:0] {
        TAG_INIT  = 2'd0,
        TAG_RUN   = 2'd1,
        TAG_FLUSH = 2'd2
    } tag_ctrl_state_e;

endpackage

// File: rtl/snitch_icache_tag_cmp.sv
// Per-set tag compare with a lowest-set-first priority encoder.
// Purely combinational; fed by the tag SRAM read data one cycle after a lookup read.
module snitch_icache_tag_cmp
    import snitch_icache_pkg::*;
#(
    parameter int unsigned SET_COUNT = 2,
    parameter int unsigned TAG_WIDTH = 20,
    localparam int unsigned SET_ALIGN = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
    localparam int unsigned ENTRY_W   = TAG_WIDTH + 2
) (
    input  logic [SET_COUNT*ENTRY_W-1:0] rtag_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    output logic [SET_COUNT-1:0]         hits_o,
    output logic                         hit_o,
    output logic [SET_ALIGN-1:0]         set_o,
    output logic                         error_o
);

    logic [SET_COUNT-1:0] err_bits;
    tag_flags_t           flags;
    logic [ENTRY_W-1:0]   entry;

    always_comb begin
        hits_o   = '0;
        err_bits = '0;
        flags    = '0;
        entry    = '0;
        set_o    = '0;
        error_o  = 1'b0;
        for (int i = 0; i < int'(SET_COUNT); i++) begin
            entry       = rtag_i[i*ENTRY_W +: ENTRY_W];
            flags       = entry[ENTRY_W-1 -: 2];
            hits_o[i]   = flags.valid && (entry[TAG_WIDTH-1:0] == tag_i);
            err_bits[i] = flags.error;
        end
        // Walk from the top down so the lowest hitting set is the one left standing.
        for (int i = int'(SET_COUNT) - 1; i >= 0; i--) begin
            if (hits_o[i]) begin
                set_o   = SET_ALIGN'(i);
                error_o = err_bits[i];
            end
        end
        hit_o = |hits_o;
    end

endmodule

// File: rtl/snitch_icache_tag_ctrl.sv
// Tag SRAM port owner: post-reset invalidation, flush, refill writes and lookup reads,
// with the hit compare one cycle after the read and a held result on out_* backpressure.
module snitch_icache_tag_ctrl
    import snitch_icache_pkg::*;
#(
    parameter int unsigned SET_COUNT  = 2,
    parameter int unsigned LINE_COUNT = 128,
    parameter int unsigned TAG_WIDTH  = 20,
    localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
    localparam int unsigned SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
    localparam int unsigned ENTRY_W     = TAG_WIDTH + 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_valid_i,
    output logic                         flush_ready_o,
    input  logic                         lookup_valid_i,
    output logic                         lookup_ready_o,
    input  logic [COUNT_ALIGN-1:0]       lookup_index_i,
    input  logic [TAG_WIDTH-1:0]         lookup_tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_hit_o,
    output logic [SET_ALIGN-1:0]         out_set_o,
    output logic                         out_error_o,
    output logic [COUNT_ALIGN-1:0]       out_index_o,
    output logic [TAG_WIDTH-1:0]         out_tag_o,
    input  logic                         write_valid_i,
    output logic                         write_ready_o,
    input  logic [COUNT_ALIGN-1:0]       write_index_i,
    input  logic [SET_ALIGN-1:0]         write_set_i,
    input  logic [TAG_WIDTH-1:0]         write_tag_i,
    input  logic                         write_error_i,
    output logic [SET_COUNT-1:0]         ram_enable_o,
    output logic                         ram_write_o,
    output logic [COUNT_ALIGN-1:0]       ram_addr_o,
    output logic [SET_COUNT*ENTRY_W-1:0] ram_wtag_o,
    input  logic [SET_COUNT*ENTRY_W-1:0] ram_rtag_i
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // ready never depends on its own valid, and an offered out_* result stays stable until taken.

    localparam logic [COUNT_ALIGN-1:0] LAST_LINE = COUNT_ALIGN'(LINE_COUNT - 1);

    tag_ctrl_state_e          state_q, state_d;
    logic [COUNT_ALIGN-1:0]   cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic                     hold_q, hold_d;
    logic                     hold_hit_q, hold_hit_d;
    logic [SET_ALIGN-1:0]     hold_set_q, hold_set_d;
    logic                     hold_err_q, hold_err_d;
    logic [COUNT_ALIGN-1:0]   idx_q, idx_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;

    logic [SET_COUNT-1:0]     cmp_hits;
    logic                     cmp_hit;
    logic [SET_ALIGN-1:0]     cmp_set;
    logic                     cmp_err;

    snitch_icache_tag_cmp #(
        .SET_COUNT (SET_COUNT),
        .TAG_WIDTH (TAG_WIDTH)
    ) i_tag_cmp (
        .rtag_i  (ram_rtag_i),
        .tag_i   (tag_q),
        .hits_o  (cmp_hits),
        .hit_o   (cmp_hit),
        .set_o   (cmp_set),
        .error_o (cmp_err)
    );

    // The live compare is shown in the cycle after the read; later cycles show the held copy.
    assign out_valid_o = pend_q | hold_q;
    assign out_hit_o   = pend_q ? cmp_hit : hold_hit_q;
    assign out_set_o   = pend_q ? cmp_set : hold_set_q;
    assign out_error_o = pend_q ? cmp_err : hold_err_q;
    assign out_index_o = idx_q;
    assign out_tag_o   = tag_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_d         = 1'b0;
        idx_d          = idx_q;
        tag_d          = tag_q;
        flush_ready_o  = 1'b0;
        write_ready_o  = 1'b0;
        lookup_ready_o = 1'b0;
        ram_enable_o   = '0;
        ram_write_o    = 1'b0;
        ram_addr_o     = '0;
        ram_wtag_o     = '0;
        if (rst_ni) begin
            unique case (state_q)
                TAG_INIT, TAG_FLUSH: begin
                    ram_enable_o = '1;
                    ram_write_o  = 1'b1;
                    ram_addr_o   = cnt_q;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == LAST_LINE) begin
                        state_d = TAG_RUN;
                        cnt_d   = '0;
                    end
                end
                TAG_RUN: begin
                    flush_ready_o  = !out_valid_o;
                    write_ready_o  = !flush_valid_i;
                    lookup_ready_o = !flush_valid_i && !write_valid_i
                                     && (!out_valid_o || out_ready_i);
                    if (flush_valid_i && flush_ready_o) begin
                        state_d = TAG_FLUSH;
                        cnt_d   = '0;
                    end else if (write_valid_i && write_ready_o) begin
                        ram_enable_o = SET_COUNT'(1) << write_set_i;
                        ram_write_o  = 1'b1;
                        ram_addr_o   = write_index_i;
                        ram_wtag_o   = {SET_COUNT{1'b1, write_error_i, write_tag_i}};
                    end else if (lookup_valid_i && lookup_ready_o) begin
                        ram_enable_o = '1;
                        ram_addr_o   = lookup_index_i;
                        pend_d       = 1'b1;
                        idx_d        = lookup_index_i;
                        tag_d        = lookup_tag_i;
                    end
                end
                default: state_d = TAG_INIT;
            endcase
        end
    end

    always_comb begin
        hold_d     = hold_q;
        hold_hit_d = hold_hit_q;
        hold_set_d = hold_set_q;
        hold_err_d = hold_err_q;
        if (pend_q && !out_ready_i) begin
            hold_d     = 1'b1;
            hold_hit_d = cmp_hit;
            hold_set_d = cmp_set;
            hold_err_d = cmp_err;
        end else if (out_ready_i) begin
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= TAG_INIT;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            hold_q     <= 1'b0;
            hold_hit_q <= 1'b0;
            hold_set_q <= '0;
            hold_err_q <= 1'b0;
            idx_q      <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            hold_hit_q <= hold_hit_d;
            hold_set_q <= hold_set_d;
            hold_err_q <= hold_err_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
        end
    end

    // At most one set may hold a given tag at a given index.
    a_single_hit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pend_q |-> $onehot0(cmp_hits));

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Directed bench for snitch_icache_tag_ctrl with a behavioural two-way tag SRAM attached.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_snitch_icache_tag_ctrl;

    localparam int SC = 2;
    localparam int LC = 128;
    localparam int TW = 20;
    localparam int CA = 7;
    localparam int SA = 1;
    localparam int EW = TW + 2;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_valid_i = 1'b0;
    logic             flush_ready_o;
    logic             lookup_valid_i = 1'b0;
    logic             lookup_ready_o;
    logic [CA-1:0]    lookup_index_i = '0;
    logic [TW-1:0]    lookup_tag_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic             out_hit_o;
    logic [SA-1:0]    out_set_o;
    logic             out_error_o;
    logic [CA-1:0]    out_index_o;
    logic [TW-1:0]    out_tag_o;
    logic             write_valid_i = 1'b0;
    logic             write_ready_o;
    logic [CA-1:0]    write_index_i = '0;
    logic [SA-1:0]    write_set_i = '0;
    logic [TW-1:0]    write_tag_i = '0;
    logic             write_error_i = 1'b0;
    logic [SC-1:0]    ram_enable_o;
    logic             ram_write_o;
    logic [CA-1:0]    ram_addr_o;
    logic [SC*EW-1:0] ram_wtag_o;
    logic [SC*EW-1:0] ram_rtag_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snitch_icache_tag_ctrl #(
        .SET_COUNT  (SC),
        .LINE_COUNT (LC),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_valid_i  (flush_valid_i),
        .flush_ready_o  (flush_ready_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_ready_o (lookup_ready_o),
        .lookup_index_i (lookup_index_i),
        .lookup_tag_i   (lookup_tag_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_hit_o      (out_hit_o),
        .out_set_o      (out_set_o),
        .out_error_o    (out_error_o),
        .out_index_o    (out_index_o),
        .out_tag_o      (out_tag_o),
        .write_valid_i  (write_valid_i),
        .write_ready_o  (write_ready_o),
        .write_index_i  (write_index_i),
        .write_set_i    (write_set_i),
        .write_tag_i    (write_tag_i),
        .write_error_i  (write_error_i),
        .ram_enable_o   (ram_enable_o),
        .ram_write_o    (ram_write_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wtag_o     (ram_wtag_o),
        .ram_rtag_i     (ram_rtag_i)
    );

    // Tag SRAM model. Starts full of valid junk (tag 0x00ABC) so the clear sweep is observable,
    // and returns all-ones garbage after any cycle without a read.
    logic [EW-1:0] mem [SC][LC];

    initial begin
        for (int s = 0; s < SC; s++)
            for (int l = 0; l < LC; l++)
                mem[s][l] = 22'h200ABC;
        ram_rtag_i = '1;
    end

    always @(posedge clk) begin
        for (int s = 0; s < SC; s++)
            if (ram_enable_o[s] && ram_write_o)
                mem[s][ram_addr_o] <= ram_wtag_o[s*EW +: EW];
        if (|ram_enable_o && !ram_write_o)
            ram_rtag_i <= {mem[1][ram_addr_o], mem[0][ram_addr_o]};
        else
            ram_rtag_i <= '1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expects LC clear cycles starting from the current falling edge.
    task automatic sweep(input string name);
        for (int i = 0; i < LC; i++) begin
            #1;
            check({name, "_addr"}, 64'(ram_addr_o), 64'(i));
            check({name, "_ctl"}, {ram_write_o, ram_enable_o, flush_ready_o, write_ready_o,
                                   lookup_ready_o}, 64'b1_11_000);
            check({name, "_wtag"}, 64'(ram_wtag_o), 64'h0);
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [SA-1:0] set, input logic [CA-1:0] idx,
                            input logic [TW-1:0] tag, input logic err,
                            input logic [SC*EW-1:0] exp_wtag);
        write_valid_i = 1'b1;
        write_set_i   = set;
        write_index_i = idx;
        write_tag_i   = tag;
        write_error_i = err;
        #1;
        check("wr_ready", 64'(write_ready_o), 64'h1);
        check("wr_ram", {ram_write_o, ram_enable_o}, {1'b1, (set == 1'b1) ? 2'b10 : 2'b01});
        check("wr_addr", 64'(ram_addr_o), 64'(idx));
        check("wr_wtag", 64'(ram_wtag_o), 64'(exp_wtag));
        @(negedge clk);
        write_valid_i = 1'b0;
    endtask

    task automatic do_lookup(input logic [CA-1:0] idx, input logic [TW-1:0] tag);
        lookup_valid_i = 1'b1;
        lookup_index_i = idx;
        lookup_tag_i   = tag;
        #1;
        check("lk_ready", 64'(lookup_ready_o), 64'h1);
        check("lk_ram", {ram_write_o, ram_enable_o}, 64'b0_11);
        check("lk_addr", 64'(ram_addr_o), 64'(idx));
        @(negedge clk);
        lookup_valid_i = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic hit, input logic [SA-1:0] set,
                                 input logic err, input logic [CA-1:0] idx, input logic [TW-1:0] tag);
        #1;
        check({name, "_valid"}, 64'(out_valid_o), 64'h1);
        check({name, "_hit"}, 64'(out_hit_o), 64'(hit));
        check({name, "_set"}, 64'(out_set_o), 64'(set));
        check({name, "_err"}, 64'(out_error_o), 64'(err));
        check({name, "_idx"}, 64'(out_index_o), 64'(idx));
        check({name, "_tag"}, 64'(out_tag_o), 64'(tag));
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_ram", {ram_write_o, ram_enable_o}, 64'h0);
        check("rst_ready", {flush_ready_o, write_ready_o, lookup_ready_o}, 64'h0);
        check("rst_out_valid", 64'(out_valid_o), 64'h0);
        rst_ni = 1'b1;
        sweep("init");

        #1;
        check("run_ready", {flush_ready_o, write_ready_o, lookup_ready_o}, 64'b111);
        check("run_out_valid", 64'(out_valid_o), 64'h0);
        check("run_idle_ram", {ram_write_o, ram_enable_o}, 64'h0);
        do_lookup(7'd3, 20'h00ABC);
        expect_result("miss_after_init", 1'b0, 1'b0, 1'b0, 7'd3, 20'h00ABC);

        do_write(1'b1, 7'd5, 20'h12345, 1'b0, {2{22'h212345}});
        do_lookup(7'd5, 20'h12345);
        expect_result("hit_set1", 1'b1, 1'b1, 1'b0, 7'd5, 20'h12345);

        do_write(1'b0, 7'd9, 20'h00001, 1'b1, {2{22'h300001}});
        do_lookup(7'd9, 20'h00001);
        expect_result("hit_set0_err", 1'b1, 1'b0, 1'b1, 7'd9, 20'h00001);
        do_lookup(7'd9, 20'h00002);
        expect_result("miss_tag", 1'b0, 1'b0, 1'b0, 7'd9, 20'h00002);

        // Backpressure: result must hold while the SRAM model returns garbage.
        out_ready_i = 1'b0;
        do_lookup(7'd5, 20'h12345);
        lookup_valid_i = 1'b1;
        lookup_index_i = 7'd9;
        lookup_tag_i   = 20'h00001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("hold_valid", 64'(out_valid_o), 64'h1);
            check("hold_hit_set", {out_hit_o, out_set_o, out_error_o}, 64'b1_1_0);
            check("hold_idx_tag", {out_index_o, out_tag_o}, {7'd5, 20'h12345});
            check("hold_lk_ready", 64'(lookup_ready_o), 64'h0);
            check("hold_flush_ready", 64'(flush_ready_o), 64'h0);
            check("hold_ram", {ram_write_o, ram_enable_o}, 64'h0);
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        #1;
        check("release_hit", {out_valid_o, out_hit_o, out_set_o}, 64'b1_1_1);
        check("release_lk_ready", 64'(lookup_ready_o), 64'h1);
        check("release_ram", {ram_write_o, ram_enable_o, ram_addr_o}, {3'b0_11, 7'd9});
        @(negedge clk);
        lookup_valid_i = 1'b0;
        expect_result("b2b", 1'b1, 1'b0, 1'b1, 7'd9, 20'h00001);

        // Write beats a simultaneous lookup; the lookup then sees the new entry.
        write_valid_i = 1'b1;
        write_set_i = 1'b0;
        write_index_i = 7'd20;
        write_tag_i = 20'h55555;
        write_error_i = 1'b0;
        lookup_valid_i = 1'b1;
        lookup_index_i = 7'd20;
        lookup_tag_i = 20'h55555;
        #1;
        check("wl_ready", {write_ready_o, lookup_ready_o}, 64'b10);
        check("wl_ram", {ram_write_o, ram_enable_o, ram_addr_o}, {3'b1_01, 7'd20});
        @(negedge clk);
        write_valid_i = 1'b0;
        #1;
        check("wl_lk_ready", 64'(lookup_ready_o), 64'h1);
        check("wl_lk_ram", {ram_write_o, ram_enable_o}, 64'b0_11);
        @(negedge clk);
        lookup_valid_i = 1'b0;
        expect_result("wl_hit", 1'b1, 1'b0, 1'b0, 7'd20, 20'h55555);

        // A write to the in-flight index does not alter that lookup's result.
        do_lookup(7'd20, 20'h55555);
        write_valid_i = 1'b1;
        write_set_i = 1'b0;
        write_index_i = 7'd20;
        write_tag_i = 20'h66666;
        expect_result("rw_order", 1'b1, 1'b0, 1'b0, 7'd20, 20'h55555);
        write_valid_i = 1'b0;
        do_lookup(7'd20, 20'h66666);
        expect_result("rw_after", 1'b1, 1'b0, 1'b0, 7'd20, 20'h66666);

        // Flush beats write and lookup.
        flush_valid_i = 1'b1;
        write_valid_i = 1'b1;
        write_set_i = 1'b1;
        write_index_i = 7'd30;
        write_tag_i = 20'h00007;
        lookup_valid_i = 1'b1;
        lookup_index_i = 7'd5;
        lookup_tag_i = 20'h12345;
        #1;
        check("fl_ready", {flush_ready_o, write_ready_o, lookup_ready_o}, 64'b100);
        check("fl_ram", {ram_write_o, ram_enable_o}, 64'h0);
        @(negedge clk);
        flush_valid_i = 1'b0;
        write_valid_i = 1'b0;
        lookup_valid_i = 1'b0;
        sweep("flush");
        do_lookup(7'd5, 20'h12345);
        expect_result("miss_after_flush", 1'b0, 1'b0, 1'b0, 7'd5, 20'h12345);
        do_lookup(7'd9, 20'h00001);
        expect_result("miss_after_flush2", 1'b0, 1'b0, 1'b0, 7'd9, 20'h00001);

        // Reset at flush line 40 restarts a full INIT; a flush held through INIT goes on first RUN cycle.
        flush_valid_i = 1'b1;
        #1;
        check("fl2_ready", 64'(flush_ready_o), 64'h1);
        @(negedge clk);
        flush_valid_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            check("fl2_addr", 64'(ram_addr_o), 64'(i));
            @(negedge clk);
        end
        #1;
        check("fl2_line40", {ram_write_o, ram_enable_o, ram_addr_o}, {3'b1_11, 7'd40});
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ram", {ram_write_o, ram_enable_o}, 64'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        flush_valid_i = 1'b1;
        sweep("init2");
        #1;
        check("held_flush_ready", 64'(flush_ready_o), 64'h1);
        check("held_flush_out_valid", 64'(out_valid_o), 64'h0);
        @(negedge clk);
        flush_valid_i = 1'b0;
        sweep("flush3");
        do_lookup(7'd3, 20'h00ABC);
        expect_result("final_miss", 1'b0, 1'b0, 1'b0, 7'd3, 20'h00ABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snitch_icache_tag_ctrl.md
Name: snitch_icache_tag_ctrl

Overview:
Control stage directly upstream of the icache tag memory. It owns the tag-SRAM port and arbitrates three request sources: automatic post-reset invalidation, explicit flush, and refill tag writes. It also issues lookup reads and performs the hit/set compare on the read tags one cycle later. Lookup results go to the icache lookup/refill logic over a valid/ready handshake.

Parameters:
SET_COUNT, 2, number of ways (tag SRAM banks); power of two, at least 1
LINE_COUNT, 128, lines per way; power of two
TAG_WIDTH, 20, tag bits per entry
COUNT_ALIGN, $clog2(LINE_COUNT), derived; index width
SET_ALIGN, $clog2(SET_COUNT) (1 if SET_COUNT==1), derived; set-select width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
flush_valid_i  in  1  flush request
flush_ready_o  out  1  flush accepted
lookup_valid_i  in  1  lookup request
lookup_ready_o  out  1  lookup accepted
lookup_index_i  in  COUNT_ALIGN  line index
lookup_tag_i  in  TAG_WIDTH  tag to compare
out_valid_o  out  1  lookup result valid
out_ready_i  in  1  result consumed
out_hit_o  out  1  hit
out_set_o  out  SET_ALIGN  hitting set (0 on miss)
out_error_o  out  1  error bit of the hitting entry (0 on miss)
out_index_o  out  COUNT_ALIGN  echoed index
out_tag_o  out  TAG_WIDTH  echoed tag
write_valid_i  in  1  refill tag write
write_ready_o  out  1  write accepted
write_index_i  in  COUNT_ALIGN  line index
write_set_i  in  SET_ALIGN  target set
write_tag_i  in  TAG_WIDTH  tag
write_error_i  in  1  refill error flag
ram_enable_o  out  SET_COUNT  per-set SRAM request
ram_write_o  out  1  SRAM write enable
ram_addr_o  out  COUNT_ALIGN  SRAM address
ram_wtag_o  out  SET_COUNT x (TAG_WIDTH+2)  write data, entry layout {valid, error, tag}
ram_rtag_i  in  SET_COUNT x (TAG_WIDTH+2)  read data, valid one cycle after a read enable

Behaviour:
- Interface: one clock, clk_i; reset is synchronous and active-low, rst_ni.
- Entry layout: bit TAG_WIDTH+1 is valid, bit TAG_WIDTH is error, bits TAG_WIDTH-1:0 are the tag.
- FSM states: INIT, RUN, FLUSH. Reset enters INIT with line counter = 0.
- INIT and FLUSH, each cycle:
  - ram_enable_o = all ones, ram_write_o = 1, ram_addr_o = counter, ram_wtag_o = all zeros.
  - Counter increments; after line LINE_COUNT-1 the FSM goes to RUN. Duration is exactly LINE_COUNT cycles.
  - flush_ready_o, write_ready_o and lookup_ready_o are 0.
- RUN:
  - flush_ready_o = !out_valid_o. A flush handshake moves to FLUSH with counter = 0.
  - Priority is flush > write > lookup.
  - write_ready_o = !flush_valid_i.
  - lookup_ready_o = !flush_valid_i && !write_valid_i && (!out_valid_o || out_ready_i).
- Write fire: ram_enable_o is one-hot at write_set_i, ram_write_o = 1, ram_addr_o = write_index_i. Every element of ram_wtag_o = {1, write_error_i, write_tag_i}. A write completes in one cycle.
- Lookup fire in cycle N:
  - ram_enable_o = all ones, ram_write_o = 0, ram_addr_o = lookup_index_i. Index and tag are registered.
  - In cycle N+1, out_valid_o = 1 and hit[i] = valid[i] && (tag[i] == registered tag).
  - out_hit_o = OR of hit[]. out_set_o is the lowest hitting set. out_error_o is the error bit of that set.
- Result hold: the compare result is captured into hold registers in cycle N+1. While out_valid_o && !out_ready_i, all out_* stay stable regardless of later ram_rtag_i.
- Back-to-back: a lookup may fire in the same cycle the previous result handshakes, giving one lookup per cycle.
- Read/write ordering: a write to the index of an in-flight lookup does not affect that lookup's result. The result reflects pre-write contents.
- Idle: ram_enable_o = 0, ram_write_o = 0. ram_addr_o and ram_wtag_o are don't-care but driven to 0.
- Multiple hits are illegal. An assertion flags them; the lowest set wins.
- Reset values: all outputs 0 and out_valid_o = 0. INIT begins the cycle after reset deasserts.
- Reset asserted mid-INIT or mid-FLUSH restarts INIT from line 0. Any pending result is dropped.
- flush_valid_i held during INIT is accepted on the first RUN cycle with out_valid_o = 0.

Decomposition:
- snitch_icache_pkg gets constants TAG_VALID_BIT and TAG_ERROR_BIT and an entry typedef helper (struct {valid, error, tag}). It also gets the tag_ctrl state enum.
- Sub-module snitch_icache_tag_cmp: combinational per-set compare plus priority encoder (lzc from common_cells), producing hit, set and error.

Test Plan:
- Reset release -> 128 consecutive cycles with ram_write_o=1, ram_enable_o=2'b11, addr 0..127, wtag=0. Then ready signals rise and a lookup of index 3, tag 0x00ABC misses.
- Write set 1, index 5, tag 0x12345, error 0; then lookup index 5, tag 0x12345 -> next cycle out_valid=1, hit=1, set=1, error=0.
- Write set 0, index 9, tag 0x00001, error 1; lookup index 9, tag 0x00001 -> hit=1, set=0, error=1. Lookup index 9, tag 0x00002 -> hit=0, set=0.
- Hit result with out_ready_i low for 3 cycles -> outputs stable, lookup_ready_o=0, no SRAM read. Release -> next lookup fires in the same cycle.
- write_valid_i and lookup_valid_i together -> write fires and lookup waits. flush_valid_i with both -> flush wins, 128 clear cycles, then lookup index 5, tag 0x12345 misses.
- rst_ni pulsed low during FLUSH at line 40 -> restart at addr 0 and a full 128-cycle INIT.
